result_broadcast_unit: RTL
==========================

RESULT_BROADCAST_UNIT -- requirements
Module: result_broadcast_unit

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port aluValid  input  1  ALU result offered this cycle.
REQ-004 SHALL have port aluReady  output  1  ALU result queue can accept.
REQ-005 SHALL have port aluReg  input  5  ALU destination register.
REQ-006 SHALL have port aluData  input  64  ALU result value.
REQ-007 SHALL have port memValid  input  1  MEM result offered this cycle.
REQ-008 SHALL have port memReady  output  1  MEM result queue can accept.
REQ-009 SHALL have port memReg  input  5  MEM destination register.
REQ-010 SHALL have port memData  input  64  MEM result value.
REQ-011 SHALL have port bcastStall  input  1  consumer holds the current broadcast.
REQ-012 SHALL have port bcastValid  output  1  broadcast slot holds a result.
REQ-013 SHALL have port bcastReg  output  5  broadcast destination register.
REQ-014 SHALL have port bcastData  output  64  broadcast value.
REQ-015 SHALL have port bcastSrc  output  1  broadcast origin: 0 = ALU, 1 = MEM.

Function
REQ-016 Each source SHALL own a 2-entry FIFO (reg + data); handshake completes when valid && ready is high at a rising edge.
REQ-017 aluReady/memReady SHALL equal (own FIFO count < 2) && !reset; they SHALL NOT depend on a same-cycle dequeue.
REQ-018 A handshake with reg == 31 SHALL complete but SHALL NOT enqueue; it is never broadcast.
REQ-019 Output slot (bcastValid/Reg/Data/Src) SHALL load when !bcastValid || !bcastStall; otherwise it SHALL hold all four outputs stable.
REQ-020 On load, the slot SHALL take the granted FIFO head and pop it; if both FIFOs are empty, bcastValid SHALL go 0.
REQ-021 An entry enqueued at edge N SHALL NOT be visible to arbitration before edge N+1; minimum latency is handshake in cycle t -> bcastValid in cycle t+2.
REQ-022 Per-source order SHALL be preserved; entries are never duplicated or lost except by reset.
REQ-023 Same-edge enqueue and pop on a FIFO with count 1 SHALL leave count 1 with correct ordering.
REQ-024 With exactly one FIFO non-empty, that FIFO SHALL be granted regardless of arbitration state.
REQ-025 At most one result SHALL be broadcast per cycle.

Reset
REQ-026 While reset is high at an edge: both FIFO counts -> 0, bcastValid -> 0, bcastReg -> 0, bcastData -> 0, bcastSrc -> 0, last-grant -> MEM.
REQ-027 Reset mid-operation SHALL discard all queued and held results; no broadcast of pre-reset data after reset deasserts.
REQ-028 Handshakes during a reset cycle SHALL be ignored; ready outputs read 0 while reset is high.

Configuration
REQ-029 Macro RESULT_BCAST_ROUND_ROBIN_EN defined: when both FIFOs are non-empty at a load, grant SHALL go to the source not granted at the previous load (last-grant updated only on loads).
REQ-030 Macro RESULT_BCAST_ROUND_ROBIN_EN undefined: when both FIFOs are non-empty, ALU SHALL always win; the last-grant register SHALL NOT exist.

Verification
REQ-031 Single ALU result: aluValid=1, aluReg=5, aluData=0xAA in cycle 1 -> bcastValid=1, bcastReg=5, bcastData=0xAA, bcastSrc=0 in cycle 3 only.
REQ-032 XZR drop: memValid=1, memReg=31 -> memReady stays 1, bcastValid never asserts.
REQ-033 Contention: ALU fills regs 1,2 and MEM fills regs 3,4 in cycles 1-2 -> with macro, broadcast order 1,3,2,4; without macro, 1,2,3,4.
REQ-034 Backpressure: bcastStall=1 for 4 cycles with ALU streaming -> outputs frozen, aluReady falls to 0 once 2 entries are queued, no entry lost after the stall is released.
REQ-035 Reset mid-stream: reset asserted for 1 cycle with both FIFOs full -> next cycle bcastValid=0, both ready=1, no stale result appears afterwards.

Source files
------------

// File: rtl/result_broadcast_unit.sv
// result_broadcast_unit: merges ALU and MEM result streams through per-source 2-entry
// FIFOs into one registered broadcast slot. Optional macro: RESULT_BCAST_ROUND_ROBIN_EN.

module result_bcast_fifo (
   input  logic        clk,
   input  logic        reset,
   input  logic        push_i,
   input  logic [4:0]  reg_i,
   input  logic [63:0] data_i,
   input  logic        pop_i,
   output logic        ready_o,
   output logic        not_empty_o,
   output logic [4:0]  head_reg_o,
   output logic [63:0] head_data_o
);
   logic [1:0]  count_q, count_d;
   logic        rd_ptr_q, rd_ptr_d;
   logic [4:0]  reg_q  [2];
   logic [4:0]  reg_d  [2];
   logic [63:0] data_q [2];
   logic [63:0] data_d [2];
   logic        wr_ptr_s;
   logic        push_s;
   logic        pop_s;

   assign ready_o     = (count_q < 2'd2) && !reset;
   assign not_empty_o = (count_q != 2'd0);
   assign push_s      = push_i && ready_o;
   assign pop_s       = pop_i && not_empty_o;
   // Tail slot is head+count; with count 1 a simultaneous pop still lands the new entry behind the head.
   assign wr_ptr_s    = rd_ptr_q ^ count_q[0];
   assign head_reg_o  = reg_q[rd_ptr_q];
   assign head_data_o = data_q[rd_ptr_q];

   // Next-state for storage, read pointer and occupancy.
   always_comb begin
      count_d  = count_q;
      rd_ptr_d = rd_ptr_q;
      for (int i = 0; i < 2; i++) begin
         if (push_s && (wr_ptr_s == 1'(i))) begin
            reg_d[i]  = reg_i;
            data_d[i] = data_i;
         end else begin
            reg_d[i]  = reg_q[i];
            data_d[i] = data_q[i];
         end
      end
      if (pop_s) begin
         rd_ptr_d = ~rd_ptr_q;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   // FIFO state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q  <= 2'd0;
         rd_ptr_q <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            reg_q[i]  <= 5'd0;
            data_q[i] <= 64'd0;
         end
      end else begin
         count_q  <= count_d;
         rd_ptr_q <= rd_ptr_d;
         for (int i = 0; i < 2; i++) begin
            reg_q[i]  <= reg_d[i];
            data_q[i] <= data_d[i];
         end
      end
   end
endmodule

module result_broadcast_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        aluValid,
   output logic        aluReady,
   input  logic [4:0]  aluReg,
   input  logic [63:0] aluData,
   input  logic        memValid,
   output logic        memReady,
   input  logic [4:0]  memReg,
   input  logic [63:0] memData,
   input  logic        bcastStall,
   output logic        bcastValid,
   output logic [4:0]  bcastReg,
   output logic [63:0] bcastData,
   output logic        bcastSrc
);
   logic        alu_ready_s, alu_ne_s, alu_push_s, alu_pop_s;
   logic [4:0]  alu_head_reg_s;
   logic [63:0] alu_head_data_s;
   logic        mem_ready_s, mem_ne_s, mem_push_s, mem_pop_s;
   logic [4:0]  mem_head_reg_s;
   logic [63:0] mem_head_data_s;
   logic        load_s;
   logic        grant_mem_s;
   logic        bcast_valid_q, bcast_valid_d;
   logic [4:0]  bcast_reg_q, bcast_reg_d;
   logic [63:0] bcast_data_q, bcast_data_d;
   logic        bcast_src_q, bcast_src_d;

   // Register 31 is the zero register: the handshake completes but nothing is queued.
   assign alu_push_s = aluValid && alu_ready_s && (aluReg != 5'd31);
   assign mem_push_s = memValid && mem_ready_s && (memReg != 5'd31);
   assign load_s     = !bcast_valid_q || !bcastStall;

   result_bcast_fifo u_alu_fifo (
      .clk         (clk),
      .reset       (reset),
      .push_i      (alu_push_s),
      .reg_i       (aluReg),
      .data_i      (aluData),
      .pop_i       (alu_pop_s),
      .ready_o     (alu_ready_s),
      .not_empty_o (alu_ne_s),
      .head_reg_o  (alu_head_reg_s),
      .head_data_o (alu_head_data_s)
   );

   result_bcast_fifo u_mem_fifo (
      .clk         (clk),
      .reset       (reset),
      .push_i      (mem_push_s),
      .reg_i       (memReg),
      .data_i      (memData),
      .pop_i       (mem_pop_s),
      .ready_o     (mem_ready_s),
      .not_empty_o (mem_ne_s),
      .head_reg_o  (mem_head_reg_s),
      .head_data_o (mem_head_data_s)
   );

`ifdef RESULT_BCAST_ROUND_ROBIN_EN
   logic last_grant_q, last_grant_d;

   // Alternate on contention; last grant (1 = MEM) only moves when a load actually takes an entry.
   always_comb begin
      grant_mem_s = mem_ne_s && (!alu_ne_s || !last_grant_q);
      if (load_s && (alu_ne_s || mem_ne_s)) begin
         last_grant_d = grant_mem_s;
      end else begin
         last_grant_d = last_grant_q;
      end
   end

   // Last-grant register.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant_q <= 1'b1;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end
`else
   assign grant_mem_s = mem_ne_s && !alu_ne_s;
`endif

   assign alu_pop_s = load_s && alu_ne_s && !grant_mem_s;
   assign mem_pop_s = load_s && grant_mem_s;

   // Broadcast slot next-state: take the granted head on load, otherwise hold.
   always_comb begin
      bcast_valid_d = bcast_valid_q;
      bcast_reg_d   = bcast_reg_q;
      bcast_data_d  = bcast_data_q;
      bcast_src_d   = bcast_src_q;
      if (load_s) begin
         bcast_valid_d = alu_ne_s || mem_ne_s;
         if (grant_mem_s) begin
            bcast_reg_d  = mem_head_reg_s;
            bcast_data_d = mem_head_data_s;
            bcast_src_d  = 1'b1;
         end else if (alu_ne_s) begin
            bcast_reg_d  = alu_head_reg_s;
            bcast_data_d = alu_head_data_s;
            bcast_src_d  = 1'b0;
         end else begin
            bcast_reg_d  = 5'd0;
            bcast_data_d = 64'd0;
            bcast_src_d  = 1'b0;
         end
      end else begin
         bcast_valid_d = bcast_valid_q;
      end
   end

   // Broadcast slot registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         bcast_valid_q <= 1'b0;
         bcast_reg_q   <= 5'd0;
         bcast_data_q  <= 64'd0;
         bcast_src_q   <= 1'b0;
      end else begin
         bcast_valid_q <= bcast_valid_d;
         bcast_reg_q   <= bcast_reg_d;
         bcast_data_q  <= bcast_data_d;
         bcast_src_q   <= bcast_src_d;
      end
   end

   assign aluReady   = alu_ready_s;
   assign memReady   = mem_ready_s;
   assign bcastValid = bcast_valid_q;
   assign bcastReg   = bcast_reg_q;
   assign bcastData  = bcast_data_q;
   assign bcastSrc   = bcast_src_q;
endmodule
